// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path (and the future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int frame_cycles(int data_bits, int parity, int stop_bits, int div);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Valid/ready word handshake into the UART transmit FIFO.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible on rdata while not empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO; DATA_BITS-wide frames, optional parity, 1 or 2 stop bits.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst_n,
    uart_tx_fifo_if.slave               host,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int DIV    = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < PAR_NONE || PARITY > PAR_EVEN ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_fifo: illegal parameter combination");
    end

    function automatic logic parity_of(logic [DATA_BITS-1:0] word);
        return (PARITY == PAR_ODD) ? ~(^word) : ^word;
    endfunction

    tx_state_e            state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 baud_end;
    logic                 stop_end;
    logic                 line;

    assign host.tx_ready = !fifo_full;
    assign push          = host.tx_valid && !fifo_full;
    assign baud_end      = (baud_cnt == BAUD_LAST);
    assign stop_end      = (state == ST_STOP) && baud_end && (bit_cnt == STOP_LAST);
    assign pop           = !fifo_empty && ((state == ST_IDLE) || stop_end);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (push),
        .wdata     (host.tx_data),
        .pop       (pop),
        .rdata     (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_level)
    );

    always_comb begin
        line = 1'b1;
        case (state)
            ST_START:  line = 1'b0;
            ST_DATA:   line = shreg[0];
            ST_PARITY: line = par_bit;
            default:   line = 1'b1;
        endcase
    end

    // Word and parity are captured at pop, so tx_data may change freely afterwards.
    always_ff @(posedge sys_clk) begin
        if (pop) begin
            shreg   <= fifo_rdata;
            par_bit <= parity_of(fifo_rdata);
        end else if (state == ST_DATA && baud_end) begin
            shreg <= shreg >> 1;
        end
    end

    // tx follows the state one cycle later, so every bit still lasts exactly DIV cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx      <= line;
            tx_done <= 1'b0;
            if (state != ST_IDLE) baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state    <= ST_START;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_end) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (baud_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_end) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (baud_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            tx_done  <= 1'b1;
                            bit_cnt  <= '0;
                            baud_cnt <= '0;
                            if (pop) begin
                                state <= ST_START;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations (8N1, 8E1, 9N2, 8O1) checked against a frame-level line model.
module tb_uart_tx_fifo;

    localparam int DIV = 10;
    localparam int NDUT = 4;
    localparam int DB [NDUT] = '{8, 8, 9, 8};
    localparam int PM [NDUT] = '{0, 2, 0, 1};
    localparam int SB [NDUT] = '{1, 1, 2, 1};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       v [NDUT];
    logic [8:0] d [NDUT];
    logic       rdy [NDUT];
    logic       tx_s [NDUT];
    logic       busy_s [NDUT];
    logic       done_s [NDUT];
    logic [4:0] lvl_s [NDUT];

    uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_b ();
    uart_tx_fifo_if #(.DATA_BITS(9)) if_c ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_d ();

    assign if_a.tx_valid = v[0];  assign if_a.tx_data = d[0][7:0];  assign rdy[0] = if_a.tx_ready;
    assign if_b.tx_valid = v[1];  assign if_b.tx_data = d[1][7:0];  assign rdy[1] = if_b.tx_ready;
    assign if_c.tx_valid = v[2];  assign if_c.tx_data = d[2];       assign rdy[2] = if_c.tx_ready;
    assign if_d.tx_valid = v[3];  assign if_d.tx_data = d[3][7:0];  assign rdy[3] = if_d.tx_ready;

    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .sys_clk(clk), .sys_rst_n(rst_n), .host(if_a), .tx(tx_s[0]), .busy(busy_s[0]),
        .tx_done(done_s[0]), .fifo_level(lvl_s[0]));
    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) dut_b (
        .sys_clk(clk), .sys_rst_n(rst_n), .host(if_b), .tx(tx_s[1]), .busy(busy_s[1]),
        .tx_done(done_s[1]), .fifo_level(lvl_s[1]));
    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(9), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) dut_c (
        .sys_clk(clk), .sys_rst_n(rst_n), .host(if_c), .tx(tx_s[2]), .busy(busy_s[2]),
        .tx_done(done_s[2]), .fifo_level(lvl_s[2]));
    uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(16)) dut_d (
        .sys_clk(clk), .sys_rst_n(rst_n), .host(if_d), .tx(tx_s[3]), .busy(busy_s[3]),
        .tx_done(done_s[3]), .fifo_level(lvl_s[3]));

    int ntests = 0;
    int nfail = 0;

    // Words accepted per DUT (written by stimulus) and frame-tracking state (written by the monitor).
    logic [8:0] hist [NDUT][128];
    int         wr_n [NDUT];
    int         rd_n [NDUT];
    int         st   [NDUT][128];
    logic       in_fr [NDUT];
    int         fc    [NDUT];
    int         good  [NDUT];
    int         dmis  [NDUT];
    logic [8:0] cur   [NDUT];
    int         ndone [NDUT];
    int         stray [NDUT];

    task automatic check(string tag, int got, int exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int flen(int i);
        return (1 + DB[i] + ((PM[i] != 0) ? 1 : 0) + SB[i]) * DIV;
    endfunction

    // Expected line level for bit slot k of a frame carrying word w.
    function automatic logic exp_bit(int i, int k, logic [8:0] w);
        logic p;
        if (k == 0) return 1'b0;
        if (k <= DB[i]) return w[k-1];
        if (PM[i] != 0 && k == DB[i] + 1) begin
            p = 1'b0;
            for (int b = 0; b < DB[i]; b++) p = p ^ w[b];
            return (PM[i] == 1) ? ~p : p;
        end
        return 1'b1;
    endfunction

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int i = 0; i < NDUT; i++) begin
                    in_fr[i] = 1'b0;
                    rd_n[i]  = wr_n[i];
                end
            end else begin
                for (int i = 0; i < NDUT; i++) begin
                    if (done_s[i]) ndone[i]++;
                    if (!in_fr[i]) begin
                        if (done_s[i]) stray[i]++;
                        if (!tx_s[i]) begin
                            in_fr[i] = 1'b1;
                            fc[i] = 0; good[i] = 0; dmis[i] = 0;
                            if (rd_n[i] == wr_n[i]) begin
                                check($sformatf("dut%0d_frame_expected", i), 0, 1);
                                cur[i] = '0;
                            end else begin
                                cur[i] = hist[i][rd_n[i]];
                                st[i][rd_n[i]] = cyc;
                                rd_n[i]++;
                            end
                        end
                    end
                    if (in_fr[i]) begin
                        if (tx_s[i] == exp_bit(i, fc[i] / DIV, cur[i])) good[i]++;
                        if ((done_s[i] == 1'b1) != (fc[i] == flen(i) - 1)) dmis[i]++;
                        if (fc[i] % DIV == DIV - 1) begin
                            check($sformatf("dut%0d_word%0h_bit%0d", i, cur[i], fc[i] / DIV), good[i], DIV);
                            good[i] = 0;
                        end
                        if (fc[i] == flen(i) - 1) begin
                            check($sformatf("dut%0d_done_pos", i), dmis[i], 0);
                            in_fr[i] = 1'b0;
                        end else begin
                            fc[i]++;
                        end
                    end
                end
            end
        end
    endtask

    // Called near a falling edge; the word is accepted at the following rising edge.
    task automatic push1(int i, logic [8:0] w, output int acc_edge);
        check($sformatf("dut%0d_ready", i), rdy[i], 1);
        v[i] = 1'b1;
        d[i] = w;
        acc_edge = cyc + 1;
        @(posedge clk);
        hist[i][wr_n[i]] = (DB[i] == 9) ? w : {1'b0, w[7:0]};
        wr_n[i]++;
        @(negedge clk);
        v[i] = 1'b0;
    endtask

    task automatic wait_drain(int i, int budget);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        #1;
        while (!(rd_n[i] == wr_n[i] && !in_fr[i]) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("dut%0d_drain_in_time", i), (n < budget) ? 1 : 0, 1);
    endtask

    initial begin
        int n0, idx, nd0, lvl, sent, c, first_full, exp_rdy, pop, base, ae, n;
        logic [7:0] bw [20];

        for (int i = 0; i < NDUT; i++) begin
            v[i] = 1'b0; d[i] = '0; wr_n[i] = 0; rd_n[i] = 0; in_fr[i] = 1'b0;
            fc[i] = 0; good[i] = 0; dmis[i] = 0; cur[i] = '0; ndone[i] = 0; stray[i] = 0;
        end
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("dut%0d_rst_tx", i), tx_s[i], 1);
            check($sformatf("dut%0d_rst_ready", i), rdy[i], 1);
            check($sformatf("dut%0d_rst_busy", i), busy_s[i], 0);
            check($sformatf("dut%0d_rst_done", i), done_s[i], 0);
            check($sformatf("dut%0d_rst_level", i), lvl_s[i], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1 0x55 from idle: latency, level and busy timing
        idx = wr_n[0];
        push1(0, 9'h055, n0);
        check("a_level_after_push", lvl_s[0], 1);
        @(negedge clk);
        check("a_level_after_pop", lvl_s[0], 0);
        check("a_busy_in_frame", busy_s[0], 1);
        wait_drain(0, 400);
        check("a_start_latency", st[0][idx] - n0, 2);
        check("a_busy_after", busy_s[0], 0);

        // parity and 9-bit frames
        push1(1, 9'h007, ae);
        push1(3, 9'h007, ae);
        push1(2, 9'h1A5, ae);
        wait_drain(1, 400);
        wait_drain(3, 400);
        wait_drain(2, 400);

        // burst of 20 with valid held high; FIFO model: accept while below 16, pop every 100 cycles
        for (int k = 0; k < 20; k++) bw[k] = 8'($urandom_range(0, 255));
        base = wr_n[0]; nd0 = ndone[0];
        lvl = 0; sent = 0; c = 0; first_full = -1;
        while (sent < 20 && c < 1000) begin
            v[0] = 1'b1;
            d[0] = {1'b0, bw[sent]};
            exp_rdy = (lvl < 16) ? 1 : 0;
            check("burst_ready", rdy[0], exp_rdy);
            if (!rdy[0] && first_full < 0) first_full = sent;
            @(posedge clk);
            pop = (c % 100 == 1 && lvl > 0) ? 1 : 0;
            if (exp_rdy == 1) begin
                hist[0][wr_n[0]] = {1'b0, bw[sent]};
                wr_n[0]++;
                sent++;
            end
            lvl = lvl + exp_rdy - pop;
            @(negedge clk);
            #1;
            if (sent == 20) v[0] = 1'b0;
            check("burst_level", lvl_s[0], lvl);
            c++;
        end
        v[0] = 1'b0;
        check("burst_accepts_at_full", first_full, 17);
        wait_drain(0, 2500);
        check("burst_done_pulses", ndone[0] - nd0, 20);
        for (int k = 0; k < 19; k++)
            check($sformatf("burst_gap_%0d", k), st[0][base+k+1] - st[0][base+k], 100);

        // reset during data bit 3 with 4 words queued
        for (int k = 0; k < 5; k++) push1(0, 9'(8'hA0 + k), ae);
        n = 0;
        while (!(in_fr[0] && fc[0] >= 45) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("rst_reached_bit3", (n < 200) ? 1 : 0, 1);
        check("rst_level_before", lvl_s[0], 4);
        check("rst_busy_before", busy_s[0], 1);
        nd0 = ndone[0];
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx_s[0], 1);
        check("rst_mid_level", lvl_s[0], 0);
        check("rst_mid_busy", busy_s[0], 0);
        check("rst_mid_ready", rdy[0], 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_after_level", lvl_s[0], 0);
        check("rst_after_tx", tx_s[0], 1);
        push1(0, 9'h03C, ae);
        wait_drain(0, 300);
        check("rst_done_count", ndone[0] - nd0, 1);

        // random words to random configurations with random gaps
        for (int k = 0; k < 24; k++) begin
            int i;
            i = $urandom_range(0, NDUT - 1);
            push1(i, 9'($urandom_range(0, 511)), ae);
            repeat ($urandom_range(0, 60)) @(negedge clk);
        end
        for (int i = 0; i < NDUT; i++) wait_drain(i, 3000);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("dut%0d_stray_done", i), stray[i], 0);
            check($sformatf("dut%0d_idle_tx", i), tx_s[i], 1);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO. It serialises words of configurable width with optional parity and one or two stop bits. It accepts data through a valid/ready handshake, so upstream logic can queue a burst without tracking per-byte completion. It sits between protocol/command logic and the board `tx` pin and replaces the fixed 8-bit, single-buffer transmitter.

## Interface
- `CLK_FREQ`, 50_000_000, sys_clk frequency in Hz
- `BAUD_RATE`, 115_200, line rate in bit/s
- `DATA_BITS`, 8, data bits per frame, legal 5..9
- `PARITY`, 0, parity mode: 0 none, 1 odd, 2 even
- `STOP_BITS`, 1, stop bits, legal 1 or 2
- `FIFO_DEPTH`, 16, FIFO entries, power of two, ≥2
- `sys_clk`  in  1  system clock
- `sys_rst_n`  in  1  asynchronous, active-low reset
- `tx_data`  in  DATA_BITS  word to queue
- `tx_valid`  in  1  `tx_data` is valid
- `tx_ready`  out  1  FIFO can accept a word (= not full)
- `tx`  out  1  serial line, idle high, registered
- `busy`  out  1  a frame is being shifted (state ≠ IDLE)
- `tx_done`  out  1  one-cycle pulse at the end of each frame
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of words queued, excluding the word in the shifter

## Operation
- Bit period `DIV = CLK_FREQ / BAUD_RATE`, truncated. Elaboration fails if DIV < 2 or any parameter is outside its legal range.
- Push: a word is written on every edge where `tx_valid && tx_ready`. `tx_ready` depends only on the FIFO count. When the FIFO is full, `tx_ready` = 0 even if a pop occurs in the same cycle.
- Pop: the FSM pops into the shift register in IDLE whenever the FIFO is non-empty. The word is latched at pop, so later changes on `tx_data` have no effect.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on pop.
  - START → DATA after DIV cycles.
  - DATA → PARITY (PARITY≠0) or STOP after DATA_BITS×DIV cycles.
  - PARITY → STOP after DIV cycles.
  - STOP → START, with a same-cycle pop, if the FIFO is non-empty after STOP_BITS×DIV cycles; otherwise STOP → IDLE.
- Line levels:
  - START: `tx` = 0.
  - DATA: data is sent LSB first.
  - PARITY: even = XOR of the data bits; odd = inverted XOR.
  - STOP and IDLE: `tx` = 1.
- Counters: the baud counter is `$clog2(DIV)` bits wide and wraps at DIV-1. The bit counter is `$clog2(DATA_BITS)+1` bits wide. Both clear on entry to START.
- `tx_done` pulses in the last cycle of the final stop bit, including between back-to-back frames.
- Reset mid-frame aborts the frame asynchronously and empties the FIFO.
- Reset values: `tx`=1, `tx_ready`=1, `busy`=0, `tx_done`=0, `fifo_level`=0.

## Timing
- Idle latency: accept at edge N → pop at N+1 → `tx` falls at N+2.
- Frame length is exactly (1 + DATA_BITS + (PARITY≠0) + STOP_BITS)×DIV cycles. Every bit lasts exactly DIV cycles, with no jitter.
- Back-to-back frames have zero idle gap: the next start bit begins the cycle after the last stop-bit cycle.
- `fifo_level` updates one cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- `busy` rises with START and falls on the cycle the FSM returns to IDLE.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum;
  - parity mode constants `PAR_NONE`/`PAR_ODD`/`PAR_EVEN`;
  - a frame-length helper function.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH) provides `full`/`empty`/`count` and is reused by the future receiver path.
- The top module contains only the FSM, the baud and bit counters, the shift register and the parity logic.

## Test plan
Benches use CLK_FREQ=1_000_000 and BAUD_RATE=100_000, giving DIV=10.
- **8N1, 0x55:** `tx` reads 0,1,0,1,0,1,0,1,0,1 at 10 cycles per bit. `tx_done` pulses at cycle 100 after the start edge; `busy` is 0 afterwards.
- **8E1, 0x07:** parity bit = 1 and the frame is 110 cycles. **8O1, 0x07:** parity bit = 0.
- **Burst, DEPTH=16:** 20 words pushed with `tx_valid` held high from idle. `tx_ready` drops after the 17th accept. All 20 frames are contiguous with no gap, 20 `tx_done` pulses occur, and the data order is preserved.
- **9N2, 0x1A5:** frame is 120 cycles. The 9th data bit = 1, followed by two stop bits.
- **Reset mid-frame:** `sys_rst_n` low during bit 3 with 4 words queued. `tx`=1 immediately and `fifo_level`=0. No `tx_done` occurs and the next push transmits cleanly.
- **Full + pop same cycle:** `tx_valid` held during the pop cycle while full. The word is not accepted and `fifo_level` drops to DEPTH-1.
